imem_loader: RTL

- Downstream of the pad ring's two-flop synchronisers in MODE_MEMLOAD; upstream of the instruction-memory write port inside `digital`.
- Frame format: one address field (2 bytes for the 10-bit default) followed by one data word (5 bytes for the 40-bit default), strobed in on port A.
- Validates the frame, then issues exactly one write pulse per host commit.
- Keeps sticky error flags and a count of committed words for host-side checking.

---
 rtl/imem_loader.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader
// -----------------------------------------------------------------------------
// Assembles instruction-memory write frames from a byte stream arriving on the
// synchronised port-A pads during memory-load mode. A frame is a 2-byte address
// field (MSB first) followed by DATA_W/8 data bytes (MSB first). Once a frame
// is complete it is held until the host raises commit, which produces exactly
// one single-cycle imem_write strobe.
//
// Ports:
//   clk_int        in   core clock, all state on rising edge
//   reset          in   synchronous active-high reset
//   load_en        in   high during memory-load mode; low aborts a partial frame
//   byte_clk       in   synchronised byte strobe level (rising edge = byte valid)
//   byte_in[7:0]   in   synchronised byte, sampled on the byte_clk edge cycle
//   commit         in   synchronised write-request level (rising edge = commit)
//   imem_write_adr out  assembled address (ADDR_W)
//   imem_in        out  assembled data word (DATA_W)
//   imem_write     out  single-cycle write strobe
//   frame_ready    out  complete frame held, awaiting commit
//   word_count     out  number of writes issued, wraps at 2^ADDR_W
//   err_addr       out  sticky: address field had bits set above ADDR_W
//   err_overrun    out  sticky: byte arrived while a complete frame was held
//   err_commit     out  sticky: commit arrived with no complete frame
//   dbg_state[1:0] out  current FSM state (0 IDLE, 1 ADDR, 2 DATA, 3 FULL)
//
// Handshake: the upstream side has no ready; a byte is accepted on every
// byte_clk rising edge seen at a clock edge, and one is accepted at most every
// 2 cycles because byte_clk must be low for at least a cycle between bytes.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 40
) (
  input  logic              clk_int,
  input  logic              reset,
  input  logic              load_en,
  input  logic              byte_clk,
  input  logic [7:0]        byte_in,
  input  logic              commit,
  output logic [ADDR_W-1:0] imem_write_adr,
  output logic [DATA_W-1:0] imem_in,
  output logic              imem_write,
  output logic              frame_ready,
  output logic [ADDR_W-1:0] word_count,
  output logic              err_addr,
  output logic              err_overrun,
  output logic              err_commit,
  output logic [1:0]        dbg_state
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_FULL = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          addr_hi_q, addr_hi_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   adr_out_q, adr_out_d;
  logic [DATA_W-1:0]   din_out_q, din_out_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic                err_addr_q, err_addr_d;
  logic                err_over_q, err_over_d;
  logic                err_commit_q, err_commit_d;
  logic                byte_prev_q, commit_prev_q;

  logic                byte_edge;
  logic                commit_edge;
  logic [15:0]         addr_field;
  logic [DATA_W-1:0]   data_shifted;

  assign byte_edge    = byte_clk & ~byte_prev_q;
  assign commit_edge  = commit & ~commit_prev_q;
  assign addr_field   = {addr_hi_q, byte_in};
  assign data_shifted = (data_q << 8) | DATA_W'(byte_in);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    addr_hi_d    = addr_hi_q;
    addr_d       = addr_q;
    data_d       = data_q;
    adr_out_d    = adr_out_q;
    din_out_d    = din_out_q;
    write_d      = 1'b0;
    count_d      = count_q;
    err_addr_d   = err_addr_q;
    err_over_d   = err_over_q;
    err_commit_d = err_commit_q;

    // A commit with no complete frame is only flagged; it never writes.
    if (commit_edge && state_q != S_FULL) begin
      err_commit_d = 1'b1;
    end

    if (!load_en) begin
      // Abort: drop any partial frame. A write already in write_q still fires.
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (byte_edge) begin
            addr_hi_d = byte_in;
            idx_d     = IDX_W'(1);
            state_d   = S_ADDR;
          end
        end
        S_ADDR: begin
          if (byte_edge) begin
            addr_d = addr_field[ADDR_W-1:0];
            // Shifting the full 16-bit field keeps this valid for ADDR_W == 16.
            if ((addr_field >> ADDR_W) != 16'd0) begin
              err_addr_d = 1'b1;
            end
            idx_d   = '0;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (byte_edge) begin
            data_d = data_shifted;
            if (idx_q == IDX_W'(NBYTES - 1)) begin
              // Outputs only change when a whole frame lands.
              adr_out_d = addr_q;
              din_out_d = data_shifted;
              idx_d     = '0;
              state_d   = S_FULL;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        S_FULL: begin
          // A byte here is discarded; if it coincides with commit, commit wins.
          if (byte_edge) begin
            err_over_d = 1'b1;
          end
          if (commit_edge) begin
            write_d = 1'b1;
            count_d = count_q + ADDR_W'(1);
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_int) begin
    if (reset) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      addr_hi_q     <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      adr_out_q     <= '0;
      din_out_q     <= '0;
      write_q       <= 1'b0;
      count_q       <= '0;
      err_addr_q    <= 1'b0;
      err_over_q    <= 1'b0;
      err_commit_q  <= 1'b0;
      // Track the live levels so a level high at release is not an edge.
      byte_prev_q   <= byte_clk;
      commit_prev_q <= commit;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      addr_hi_q     <= addr_hi_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      adr_out_q     <= adr_out_d;
      din_out_q     <= din_out_d;
      write_q       <= write_d;
      count_q       <= count_d;
      err_addr_q    <= err_addr_d;
      err_over_q    <= err_over_d;
      err_commit_q  <= err_commit_d;
      byte_prev_q   <= byte_clk;
      commit_prev_q <= commit;
    end
  end

  assign imem_write_adr = adr_out_q;
  assign imem_in        = din_out_q;
  assign imem_write     = write_q;
  assign frame_ready    = (state_q == S_FULL);
  assign word_count     = count_q;
  assign err_addr       = err_addr_q;
  assign err_overrun    = err_over_q;
  assign err_commit     = err_commit_q;
  assign dbg_state      = state_q;

endmodule
